// File: rtl/seq_divider_18_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and the iteration counter width.
package seq_divider_18_pkg;

   localparam int DEFAULT_WIDTH = 18;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_divider_18_if.sv
// Request/result bundle of the divider. Handshake: start is taken only while the
// divider is idle; done pulses once and the results hold until the next done.
interface seq_divider_18_if
   import seq_divider_18_pkg::*;
#(
   parameter int W = DEFAULT_WIDTH
);

   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   state_t       dbg_state;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, dbg_state
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, dbg_state
   );

endinterface

// File: rtl/addsub_18.sv
// Ripple adder/subtractor: sum = a + b (sub=0) or a - b (sub=1) via inverted b
// and carry-in, built from full-adder cells.
module addsub_18 #(
   parameter int N = 19
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   logic [N-1:0] b_x;
   logic [N-1:0] carry;

   assign b_x      = b ^ {N{sub}};
   assign carry[0] = sub;

   for (genvar i = 0; i < N - 1; i++) begin : g_fa
      fa_cell u_fa (
         .a  (a[i]),
         .b  (b_x[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   // The carry out of the top bit is never needed, so the msb is a plain sum bit.
   assign sum[N-1] = a[N-1] ^ b_x[N-1] ^ carry[N-1];

endmodule

// File: rtl/fa_cell.sv
// One-bit full adder cell used to build ripple adders.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seq_divider_18.sv
// Signed sequential divider: radix-2 non-restoring on magnitudes, one quotient
// bit per CALC cycle, then a FIX cycle for remainder restore and sign correction.
module seq_divider_18
   import seq_divider_18_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   seq_divider_18_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dbz_q, dbz_d;
   logic             dbz_out_q, dbz_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub;
   logic [WIDTH-1:0] rem_mag;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

   addsub_18 #(.N(WIDTH + 1)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .sum (as_sum)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      a_d       = a_q;
      d_d       = d_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      dbz_d     = dbz_q;
      dbz_out_d = dbz_out_q;
      done_d    = 1'b0;
      rem_mag   = '0;

      // CALC shifts {P,A} left and adds or subtracts |divisor| by the sign of P;
      // FIX reuses the same adder to restore a negative final remainder.
      as_b = {1'b0, d_q};
      if (state_q == FIX) begin
         as_a   = p_q;
         as_sub = 1'b0;
      end else begin
         as_a   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
         as_sub = ~p_q[WIDTH];
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
               r_neg_d = bus.dividend[WIDTH-1];
               if (bus.divisor == '0) begin
                  dbz_d   = 1'b1;
                  a_d     = '1;
                  p_d     = {bus.dividend[WIDTH-1], bus.dividend};
                  state_d = DONE;
               end else begin
                  dbz_d   = 1'b0;
                  a_d     = mag(bus.dividend);
                  d_d     = mag(bus.divisor);
                  p_d     = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            p_d = as_sum;
            a_d = {a_q[WIDTH-2:0], ~as_sum[WIDTH]};
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            rem_mag = p_q[WIDTH] ? as_sum[WIDTH-1:0] : p_q[WIDTH-1:0];
            p_d     = {1'b0, (r_neg_q ? (~rem_mag + 1'b1) : rem_mag)};
            a_d     = q_neg_q ? (~a_q + 1'b1) : a_q;
            state_d = DONE;
         end
         DONE: begin
            quot_d    = a_q;
            rem_d     = p_q[WIDTH-1:0];
            dbz_out_d = dbz_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         p_q       <= '0;
         a_q       <= '0;
         d_q       <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dbz_q     <= 1'b0;
         dbz_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         a_q       <= a_d;
         d_q       <= d_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         dbz_q     <= dbz_d;
         dbz_out_q <= dbz_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_out_q;
   assign bus.dbg_state   = state_q;

endmodule
